// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control path: opcodes, datapath
// mux encodings, the control FSM state set and the bundled control word.
package cpu_pkg;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_SW   = 4'd2;
  localparam logic [3:0] OP_BEQ  = 4'd3;
  localparam logic [3:0] OP_J    = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R,
    S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  // Every datapath control and status bit driven by the FSM, in one word.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
    logic       illegal_op;
    logic       bus_error;
    logic       halted;
  } ctrl_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_HALT};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request is stalled and flags the cycle
// in which the stall reaches MEM_TIMEOUT. A ready in that same cycle masks it.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic req,
  input  logic ready,
  output logic timeout
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(MEM_TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 waiting;

  assign waiting = req & ~ready;

  // Any non-stalled cycle restarts the count, so each wait state begins at zero.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (Reset || !waiting) begin
      wait_cnt <= '0;
    end else if (wait_cnt != '1) begin
      wait_cnt <= wait_cnt + TIMEOUT_W'(1);
    end
  end

  assign timeout = waiting && (wait_cnt >= LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB over the shared
// datapath, handshakes with memory and halts with a sticky bus error on timeout.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       Retire,
  output logic       IllegalOp,
  output logic       BusError,
  output logic       Halted
);

  state_t state;
  logic   bus_error;
  ctrl_t  ctrl;
  logic   timeout;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TIMEOUT_W  (TIMEOUT_W)
  ) u_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .req    (ctrl.mem_read | ctrl.mem_write),
    .ready  (MemReady),
    .timeout(timeout)
  );

  // Next-state sequencing; a memory timeout overrides the normal transition.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_FETCH;
      bus_error <= 1'b0;
    end else if (timeout) begin
      state     <= S_HALT;
      bus_error <= 1'b1;
    end else begin
      case (state)
        S_FETCH:    if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          case (Opcode)
            OP_LW, OP_SW: state <= S_MEM_ADDR;
            OP_R:         state <= S_EXEC_R;
            OP_ADDI:      state <= S_EXEC_I;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            OP_HALT:      state <= S_HALT;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: state <= (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (MemReady) state <= S_MEM_WB;
        S_MEM_WR:   if (MemReady) state <= S_FETCH;
        S_EXEC_R:   state <= S_R_WB;
        S_EXEC_I:   state <= S_I_WB;
        S_HALT:     state <= S_HALT;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the control word, with MemReady gating the handshake bits.
  always_comb begin
    // NOTE: defaulting the whole word first keeps every path assigned, so no latches are inferred.
    ctrl = '0;
    if (!Reset) begin
      ctrl.bus_error = bus_error;
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_ONE;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = MemReady;
          ctrl.pc_write  = MemReady;
        end
        S_DECODE: begin
          ctrl.alu_src_b  = SRCB_IMM;
          ctrl.illegal_op = !is_legal(Opcode);
        end
        S_MEM_ADDR, S_EXEC_I: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          ctrl.i_or_d   = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.retire     = 1'b1;
        end
        S_MEM_WR: begin
          ctrl.i_or_d    = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.retire    = MemReady;
        end
        S_EXEC_R: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_REG;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_R_WB: begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.retire    = 1'b1;
        end
        S_I_WB: begin
          ctrl.reg_write = 1'b1;
          ctrl.retire    = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_REG;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
          ctrl.retire        = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
          ctrl.retire    = 1'b1;
        end
        S_HALT:  ctrl.halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCSource    = ctrl.pc_source;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemToReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign Retire      = ctrl.retire;
  assign IllegalOp   = ctrl.illegal_op;
  assign BusError    = ctrl.bus_error;
  assign Halted      = ctrl.halted;

endmodule
